// File: rtl/i2s_frame_buffer_pkg.sv
// rtl/i2s_frame_buffer_pkg.sv - shared channel-select codes and read FSM states
// Purpose: constants and types imported by the frame buffer top and its RAM.
// Contents: CHAN_* channel-select codes, rd_state_e read FSM encoding,
//           chan_is_mono() helper.
package i2s_frame_buffer_pkg;

    localparam logic [1:0] CHAN_LEFT  = 2'b00;
    localparam logic [1:0] CHAN_RIGHT = 2'b01;
    localparam logic [1:0] CHAN_MONO  = 2'b10;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_FETCH  = 2'd1,
        RD_STREAM = 2'd2
    } rd_state_e;

    // Both 2'b10 and 2'b11 select mono.
    function automatic logic chan_is_mono(input logic [1:0] sel);
        return sel[1];
    endfunction

endpackage

// File: rtl/i2s_frame_buffer_sdp_ram.sv
// rtl/i2s_frame_buffer_sdp_ram.sv - simple dual-port RAM with registered read
// Purpose: ping-pong sample storage, one write port and one read port.
// Ports:
//   clk        in   clock
//   wr_en_i    in   write enable
//   wr_addr_i  in   write address
//   wr_data_i  in   write data
//   rd_en_i    in   read enable; rd_data_o updates only when set
//   rd_addr_i  in   read address
//   rd_data_o  out  read data, one cycle after rd_en_i
module i2s_frame_buffer_sdp_ram #(
    parameter int DATA_BITS = 24,
    parameter int ADDR_W    = 9
) (
    input  logic                 clk,
    input  logic                 wr_en_i,
    input  logic [ADDR_W-1:0]    wr_addr_i,
    input  logic [DATA_BITS-1:0] wr_data_i,
    input  logic                 rd_en_i,
    input  logic [ADDR_W-1:0]    rd_addr_i,
    output logic [DATA_BITS-1:0] rd_data_o
);

    logic [DATA_BITS-1:0] mem_q [2**ADDR_W];
    logic [DATA_BITS-1:0] rd_data_q;

    // The read register holds its value while rd_en_i is low; the top relies
    // on this to keep a prefetched sample parked until the consumer takes it.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/i2s_frame_buffer.sv
// rtl/i2s_frame_buffer.sv - I2S sample selector, ping-pong frame buffer and stream out
// Purpose: pick left/right/mono samples, pack FRAME_LEN per bank, stream full banks.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   left_data/left_valid       left sample strobe from the I2S receiver
//   right_data/right_valid     right sample strobe from the I2S receiver
//   enable                     capture enable; low discards a partial frame
//   chan_sel                   00 left, 01 right, 1x mono average
//   m_data/m_valid/m_ready     output sample stream, index 0 first
//   m_last                     marks the final sample of a frame
//   overflow/overflow_clr      sticky dropped-sample flag and its clear
module i2s_frame_buffer
    import i2s_frame_buffer_pkg::*;
#(
    parameter int DATA_BITS = 24,
    parameter int FRAME_LEN = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] left_data,
    input  logic                 left_valid,
    input  logic [DATA_BITS-1:0] right_data,
    input  logic                 right_valid,
    input  logic                 enable,
    input  logic [1:0]           chan_sel,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic                 overflow,
    input  logic                 overflow_clr
);

    localparam int ADDR_BITS = $clog2(FRAME_LEN);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(FRAME_LEN - 1);
    localparam logic [ADDR_BITS-1:0] ADDR_ZERO = '0;
    localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);
    localparam logic [ADDR_BITS-1:0] ADDR_TWO  = ADDR_BITS'(2);

    // ---------------- sample selection ----------------
    logic [DATA_BITS-1:0] held_left_q;
    logic [DATA_BITS:0]   mono_sum;
    logic                 ev_valid;
    logic [DATA_BITS-1:0] ev_data;

    // Sign-extended sum; dropping bit 0 is an arithmetic shift (floor).
    assign mono_sum = {held_left_q[DATA_BITS-1], held_left_q}
                    + {right_data[DATA_BITS-1], right_data};

    always_comb begin
        ev_valid = 1'b0;
        ev_data  = left_data;
        if (chan_is_mono(chan_sel)) begin
            ev_valid = right_valid;
            ev_data  = mono_sum[DATA_BITS:1];
        end else if (chan_sel == CHAN_RIGHT) begin
            ev_valid = right_valid;
            ev_data  = right_data;
        end else begin
            ev_valid = left_valid;
            ev_data  = left_data;
        end
    end

    // ---------------- write side ----------------
    logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
    logic                 wr_bank_q, wr_bank_d;
    logic [1:0]           bank_full_q, bank_full_d;
    logic [1:0]           set_mask, clr_mask;
    logic                 overflow_q, overflow_d;
    logic                 ram_we;

    always_comb begin
        wr_addr_d = wr_addr_q;
        wr_bank_d = wr_bank_q;
        set_mask  = 2'b00;
        ram_we    = 1'b0;
        overflow_d = overflow_q;
        if (!enable) begin
            wr_addr_d = ADDR_ZERO;
        end else if (ev_valid) begin
            if (!bank_full_q[wr_bank_q]) begin
                ram_we = 1'b1;
                if (wr_addr_q == LAST_ADDR) begin
                    set_mask[wr_bank_q] = 1'b1;
                    wr_bank_d = ~wr_bank_q;
                    wr_addr_d = ADDR_ZERO;
                end else begin
                    wr_addr_d = wr_addr_q + ADDR_ONE;
                end
            end else begin
                overflow_d = 1'b1;
            end
        end
        // A drop in the same cycle wins over the clear.
        if (overflow_clr && !(enable && ev_valid && bank_full_q[wr_bank_q])) begin
            overflow_d = 1'b0;
        end
    end

    // Set and clear always target different banks, so both apply.
    assign bank_full_d = (bank_full_q & ~clr_mask) | set_mask;

    // ---------------- read side ----------------
    rd_state_e            state_q, state_d;
    logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [DATA_BITS-1:0] m_data_q, m_data_d;
    logic                 m_valid_q, m_valid_d;
    logic                 m_last_q, m_last_d;
    logic                 ram_re;
    logic [ADDR_BITS:0]   ram_raddr;
    logic [DATA_BITS-1:0] ram_rdata;

    // rd_addr_q is the index of the sample currently presented on m_data.
    // The RAM read register always holds the following sample, so a
    // handshake can load it straight into m_data with no bubble.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        rd_bank_d = rd_bank_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        clr_mask  = 2'b00;
        ram_re    = 1'b0;
        ram_raddr = {rd_bank_q, rd_addr_q};
        case (state_q)
            RD_IDLE: begin
                if (bank_full_q[rd_bank_q]) begin
                    ram_re    = 1'b1;
                    ram_raddr = {rd_bank_q, ADDR_ZERO};
                    rd_addr_d = ADDR_ZERO;
                    state_d   = RD_FETCH;
                end
            end
            RD_FETCH: begin
                m_data_d  = ram_rdata;
                m_valid_d = 1'b1;
                m_last_d  = (rd_addr_q == LAST_ADDR);
                ram_re    = 1'b1;
                ram_raddr = {rd_bank_q, rd_addr_q + ADDR_ONE};
                state_d   = RD_STREAM;
            end
            RD_STREAM: begin
                if (m_ready) begin
                    if (m_last_q) begin
                        clr_mask[rd_bank_q] = 1'b1;
                        rd_bank_d = ~rd_bank_q;
                        rd_addr_d = ADDR_ZERO;
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        if (bank_full_q[~rd_bank_q]) begin
                            ram_re    = 1'b1;
                            ram_raddr = {~rd_bank_q, ADDR_ZERO};
                            state_d   = RD_FETCH;
                        end else begin
                            state_d   = RD_IDLE;
                        end
                    end else begin
                        m_data_d  = ram_rdata;
                        m_last_d  = (rd_addr_q + ADDR_ONE == LAST_ADDR);
                        rd_addr_d = rd_addr_q + ADDR_ONE;
                        // Wraps harmlessly inside the bank past the last sample.
                        ram_re    = 1'b1;
                        ram_raddr = {rd_bank_q, rd_addr_q + ADDR_TWO};
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_left_q <= '0;
            wr_addr_q   <= '0;
            wr_bank_q   <= 1'b0;
            bank_full_q <= 2'b00;
            overflow_q  <= 1'b0;
            state_q     <= RD_IDLE;
            rd_addr_q   <= '0;
            rd_bank_q   <= 1'b0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
        end else begin
            if (left_valid) begin
                held_left_q <= left_data;
            end
            wr_addr_q   <= wr_addr_d;
            wr_bank_q   <= wr_bank_d;
            bank_full_q <= bank_full_d;
            overflow_q  <= overflow_d;
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            rd_bank_q   <= rd_bank_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
        end
    end

    i2s_frame_buffer_sdp_ram #(
        .DATA_BITS (DATA_BITS),
        .ADDR_W    (ADDR_BITS + 1)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (ram_we),
        .wr_addr_i ({wr_bank_q, wr_addr_q}),
        .wr_data_i (ev_data),
        .rd_en_i   (ram_re),
        .rd_addr_i (ram_raddr),
        .rd_data_o (ram_rdata)
    );

    assign m_data   = m_data_q;
    assign m_valid  = m_valid_q;
    assign m_last   = m_last_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_i2s_frame_buffer.sv
// tb/tb_i2s_frame_buffer.sv - scoreboard bench for i2s_frame_buffer (FRAME_LEN=8)
module tb_i2s_frame_buffer;

    localparam int DB = 24;
    localparam int FL = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DB-1:0] left_data = '0;
    logic          left_valid = 1'b0;
    logic [DB-1:0] right_data = '0;
    logic          right_valid = 1'b0;
    logic          enable = 1'b1;
    logic [1:0]    chan_sel = 2'b00;
    logic [DB-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          m_last;
    logic          overflow;
    logic          overflow_clr = 1'b0;

    typedef struct packed {
        logic [DB-1:0] data;
        logic          last;
    } exp_t;

    exp_t          sb[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            push_idx = 0;
    bit            rand_ready = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DB-1:0] prev_data;
    logic          prev_last;

    i2s_frame_buffer #(
        .DATA_BITS (DB),
        .FRAME_LEN (FL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .left_data    (left_data),
        .left_valid   (left_valid),
        .right_data   (right_data),
        .right_valid  (right_valid),
        .enable       (enable),
        .chan_sel     (chan_sel),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_last       (m_last),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic push_exp(input logic [DB-1:0] d);
        sb.push_back('{data: d, last: (push_idx == FL - 1)});
        push_idx = (push_idx + 1) % FL;
    endtask

    task automatic send_l(input logic [DB-1:0] d);
        left_data = d;
        left_valid = 1'b1;
        tick();
        left_valid = 1'b0;
    endtask

    task automatic send_r(input logic [DB-1:0] d);
        right_data = d;
        right_valid = 1'b1;
        tick();
        right_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int c;
        c = 0;
        while (sb.size() != 0 && c < budget) begin
            tick();
            c++;
        end
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    function automatic logic [DB-1:0] mono_model(input logic [DB-1:0] l, input logic [DB-1:0] r);
        int s;
        s = int'($signed(l)) + int'($signed(r));
        s = s >>> 1;
        return s[DB-1:0];
    endfunction

    // Output monitor: stability under back-pressure and in-order scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                chk("stall_valid", 32'(m_valid), 32'd1);
                chk("stall_data", 32'(m_data), 32'(prev_data));
                chk("stall_last", 32'(m_last), 32'(prev_last));
            end
            if (m_valid && m_ready) begin
                chk("unexpected_out", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_data", 32'(m_data), 32'(e.data));
                    chk("out_last", 32'(m_last), 32'(e.last));
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        int w;
        logic [DB-1:0] l, r, d;

        // Reset state
        repeat (3) tick();
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        tick();

        // T1: left channel, back-to-back output
        chan_sel = 2'b00;
        m_ready = 1'b1;
        for (int i = 1; i <= FL; i++) begin
            push_exp(DB'(i));
            send_l(DB'(i));
        end
        w = 0;
        @(negedge clk);
        while (!m_valid && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("t1_latency", 32'(w <= 3), 32'd1);
        for (int i = 1; i < FL; i++) begin
            @(negedge clk);
            chk("t1_nogap", 32'(m_valid), 32'd1);
        end
        tick();
        wait_drain("t1_drain", 20);
        chk("t1_overflow", 32'(overflow), 32'd0);

        // T2: mono average with saturating and negative-floor cases
        chan_sel = 2'b10;
        send_l(24'h7FFFFF);
        push_exp(24'h7FFFFF);
        send_r(24'h7FFFFF);
        send_l(24'h800000);
        push_exp(24'hBFFFFF);
        send_r(24'hFFFFFF);
        for (int i = 0; i < FL - 2; i++) begin
            l = DB'($urandom);
            r = DB'($urandom);
            send_l(l);
            push_exp(mono_model(l, r));
            send_r(r);
        end
        wait_drain("t2_drain", 30);

        // T3: back-pressure, third frame dropped
        chan_sel = 2'b00;
        m_ready = 1'b0;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < FL; i++) begin
                d = DB'(32'h100 * (f + 1) + i);
                if (f < 2) push_exp(d);
                send_l(d);
            end
        end
        tick();
        chk("t3_overflow_set", 32'(overflow), 32'd1);
        chk("t3_hold_valid", 32'(m_valid), 32'd1);
        chk("t3_hold_data", 32'(m_data), 32'h100);
        m_ready = 1'b1;
        wait_drain("t3_drain", 60);
        repeat (10) tick();
        chk("t3_idle", 32'(m_valid), 32'd0);
        chk("t3_overflow_sticky", 32'(overflow), 32'd1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk("t3_overflow_clr", 32'(overflow), 32'd0);

        // T4: right channel, random back-pressure, left strobes ignored
        chan_sel = 2'b01;
        rand_ready = 1'b1;
        for (int i = 0; i < 2 * FL; i++) begin
            d = DB'($urandom);
            push_exp(d);
            send_r(d);
            tick();
            send_l(DB'($urandom));
        end
        wait_drain("t4_drain", 300);
        rand_ready = 1'b0;
        m_ready = 1'b1;
        chk("t4_overflow", 32'(overflow), 32'd0);

        // T5: partial frame discarded by enable=0
        chan_sel = 2'b00;
        for (int i = 0; i < 5; i++) send_l(DB'(32'hAA000 + i));
        enable = 1'b0;
        tick();
        send_l(24'h00DEAD);
        tick();
        enable = 1'b1;
        for (int i = 0; i < FL; i++) begin
            push_exp(DB'(32'h500 + i));
            send_l(DB'(32'h500 + i));
        end
        wait_drain("t5_drain", 30);
        repeat (10) tick();
        chk("t5_idle", 32'(m_valid), 32'd0);

        // T6: reset while streaming
        m_ready = 1'b0;
        for (int i = 0; i < 2 * FL + 1; i++) send_l(DB'(32'h900 + i));
        chk("t6_pre_valid", 32'(m_valid), 32'd1);
        chk("t6_pre_overflow", 32'(overflow), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(m_valid), 32'd0);
        chk("t6_rst_data", 32'(m_data), 32'd0);
        chk("t6_rst_last", 32'(m_last), 32'd0);
        chk("t6_rst_overflow", 32'(overflow), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        m_ready = 1'b1;
        push_idx = 0;
        for (int i = 0; i < FL; i++) begin
            push_exp(DB'(32'hC00 + i));
            send_l(DB'(32'hC00 + i));
        end
        wait_drain("t6_drain", 30);
        repeat (10) tick();
        chk("t6_idle", 32'(m_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
